// File: rtl/mini_cpu_pkg.sv
// Shared constants for the mini CPU: datapath word width and input-port FIFO geometry.
package mini_cpu_pkg;
  localparam int DATA_W       = 32;
  localparam int INPORT_DEPTH = 4;
  localparam int INPORT_PTR_W = $clog2(INPORT_DEPTH);
endpackage

// File: rtl/inport_fifo.sv
// Input-port FIFO storage: circular buffer whose full/empty state comes from an
// occupancy count, so pointer wrap never has to be disambiguated.
module inport_fifo
  import mini_cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = INPORT_DEPTH,
  parameter int PTR_W = INPORT_PTR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO is never read through head_data.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/in_port_buffer.sv
// Input-port front end: handshake into a FIFO, one pop per rising edge of InPortout.
// Define INPORT_UNDERFLOW_CHK_EN to get a sticky read-while-empty flag.
module in_port_buffer #(
  parameter int DATA_W = mini_cpu_pkg::DATA_W,
  parameter int DEPTH  = mini_cpu_pkg::INPORT_DEPTH,
  parameter int PTR_W  = mini_cpu_pkg::INPORT_PTR_W
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              InPortout,
  output logic [DATA_W-1:0] input_data,
  output logic              data_avail,
  output logic              in_underflow
);

  logic              prev_rd_q, prev_rd_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] head_data;
  logic              full, empty;
  logic              rd_evt, push, pop;

  assign rd_evt = InPortout && !prev_rd_q;
  assign push   = ext_valid && !full;
  assign pop    = rd_evt && !empty;

  assign ext_ready  = !full;
  assign data_avail = !empty;
  // hold_q keeps the last popped word so an empty read re-reads it.
  assign input_data = empty ? hold_q : head_data;

  inport_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (Reset),
    .push      (push),
    .pop       (pop),
    .wr_data   (ext_data),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    prev_rd_d = InPortout;
    hold_d    = hold_q;
    if (pop) begin
      hold_d = head_data;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      prev_rd_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      prev_rd_q <= prev_rd_d;
      hold_q    <= hold_d;
    end
  end

`ifdef INPORT_UNDERFLOW_CHK_EN
  logic underflow_q, underflow_d;

  always_comb begin
    underflow_d = underflow_q || (rd_evt && empty);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign in_underflow = underflow_q;
`else
  assign in_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_in_port_buffer.sv
// Directed bench for in_port_buffer with a queue scoreboard of accepted words.
module tb_in_port_buffer;

  logic        clock = 1'b0;
  logic        Reset;
  logic [31:0] ext_data;
  logic        ext_valid;
  logic        ext_ready;
  logic        InPortout;
  logic [31:0] input_data;
  logic        data_avail;
  logic        in_underflow;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [31:0] last_word = '0;
  logic        tb_prev = 1'b0;
  logic        exp_uflow;

  in_port_buffer dut (
    .clock        (clock),
    .Reset        (Reset),
    .ext_data     (ext_data),
    .ext_valid    (ext_valid),
    .ext_ready    (ext_ready),
    .InPortout    (InPortout),
    .input_data   (input_data),
    .data_avail   (data_avail),
    .in_underflow (in_underflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic rd);
    ext_valid = valid;
    ext_data  = data;
    InPortout = rd;
    @(posedge clock);
    #1;
  endtask

  // Mid-cycle monitor: checks flags against the model, pops on read events, pushes on handshakes.
  always @(negedge clock) begin
    if (Reset) begin
      sb.delete();
      last_word = '0;
      tb_prev   = 1'b0;
    end else begin
      checkOutput("avail_model", {31'd0, data_avail}, {31'd0, sb.size() != 0});
      checkOutput("ready_model", {31'd0, ext_ready}, {31'd0, sb.size() != 4});
      if (InPortout && !tb_prev) begin
        if (sb.size() > 0) begin
          logic [31:0] exp_word;
          exp_word = sb.pop_front();
          checkOutput("pop_data", input_data, exp_word);
          last_word = exp_word;
        end else begin
          checkOutput("empty_read", input_data, last_word);
        end
      end
      if (ext_valid && ext_ready) sb.push_back(ext_data);
      tb_prev = InPortout;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef INPORT_UNDERFLOW_CHK_EN
    exp_uflow = 1'b1;
`else
    exp_uflow = 1'b0;
`endif
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("rst_ready", {31'd0, ext_ready}, 32'd1);
    checkOutput("rst_avail", {31'd0, data_avail}, 32'd0);
    checkOutput("rst_data", input_data, 32'h0);
    checkOutput("rst_uflow", {31'd0, in_underflow}, 32'd0);
    Reset = 1'b0;

    // Single word, single pulse.
    applyStimulus(1'b1, 32'h1111_1111, 1'b0);
    checkOutput("t2_avail", {31'd0, data_avail}, 32'd1);
    checkOutput("t2_head", input_data, 32'h1111_1111);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t2_empty", {31'd0, data_avail}, 32'd0);
    checkOutput("t2_hold", input_data, 32'h1111_1111);

    // Fill to full, stall a fifth word, release it with one pop.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA0 + i, 1'b0);
    checkOutput("t3_full_ready", {31'd0, ext_ready}, 32'd0);
    applyStimulus(1'b1, 32'hA4, 1'b0);
    applyStimulus(1'b1, 32'hA4, 1'b0);
    checkOutput("t3_still_full", {31'd0, ext_ready}, 32'd0);
    applyStimulus(1'b1, 32'hA4, 1'b1);
    checkOutput("t3_ready_back", {31'd0, ext_ready}, 32'd1);
    applyStimulus(1'b1, 32'hA4, 1'b0);
    checkOutput("t3_refull", {31'd0, ext_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0);
    end
    checkOutput("t3_drained", sb.size(), 32'd0);
    checkOutput("t3_last", input_data, 32'hA4);

    // Long InPortout level pops exactly once.
    applyStimulus(1'b1, 32'hB0, 1'b0);
    applyStimulus(1'b1, 32'hB1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4_avail", {31'd0, data_avail}, 32'd1);
    checkOutput("t4_head", input_data, 32'hB1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_one_left", {31'd0, data_avail}, 32'd0);

    // Empty read re-reads the last word and raises the flag when enabled.
    applyStimulus(1'b1, 32'h5, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t5_uflow_pre", {31'd0, in_underflow}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t5_hold", input_data, 32'h5);
    checkOutput("t5_uflow", {31'd0, in_underflow}, {31'd0, exp_uflow});
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'hC0, 1'b1);
    checkOutput("t5_push_lands", {31'd0, data_avail}, 32'd1);
    checkOutput("t5_push_head", input_data, 32'hC0);
    checkOutput("t5_uflow_sticky", {31'd0, in_underflow}, {31'd0, exp_uflow});

    // Reset with three words queued.
    applyStimulus(1'b1, 32'hC1, 1'b0);
    applyStimulus(1'b1, 32'hC2, 1'b0);
    checkOutput("t6_queued", sb.size(), 32'd3);
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    Reset = 1'b0;
    checkOutput("t6_avail", {31'd0, data_avail}, 32'd0);
    checkOutput("t6_data", input_data, 32'h0);
    checkOutput("t6_uflow", {31'd0, in_underflow}, 32'd0);
    checkOutput("t6_ready", {31'd0, ext_ready}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
